fifo_word_packer: RTL and testbench
===================================

# fifo_word_packer

Width-up packer between two depth-2 FIFO stages. It dequeues narrow beats from an upstream FIFO (EMPTY_N/D_OUT/DEQ side) and assembles RATIO beats into one wide word. It enqueues that word into a downstream FIFO (ENQ/FULL_N side). It sustains one narrow beat per cycle and can optionally flush partial words on end-of-message.

## Interface
- Reset is RST, synchronous, active-high; clock is CLK.

Parameters:
- NW, default 8: narrow beat width in bits.
- RATIO, default 4: beats per wide word. Must be a power of two, 2..16.
- CW, default $clog2(RATIO)+1: width of the lane count.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- IN_DATA  in  NW  upstream FIFO head data.
- IN_EOM  in  1  end-of-message flag travelling with IN_DATA.
- IN_EMPTY_N  in  1  upstream FIFO holds data.
- IN_DEQ  out  1  dequeue strobe to the upstream FIFO.
- OUT_DATA  out  NW*RATIO  packed word.
- OUT_COUNT  out  CW  number of valid lanes in OUT_DATA (1..RATIO).
- OUT_EOM  out  1  word closes a message.
- OUT_ENQ  out  1  enqueue strobe to the downstream FIFO.
- OUT_FULL_N  in  1  downstream FIFO has space.

## Operation
- State:
  - acc: NW*RATIO accumulator.
  - idx: lane index, 0..RATIO-1.
  - out_pend, out_data, out_cnt, out_eom: output holding register.
- IN_DEQ = !RST && IN_EMPTY_N && !(out_pend && !OUT_FULL_N). The block stalls input whenever a pending word is blocked.
- OUT_ENQ = !RST && out_pend && OUT_FULL_N. OUT_ENQ is never asserted while OUT_FULL_N=0.
- Beat accept (IN_DEQ=1):
  - IN_DATA is written to lane idx, bits [idx*NW +: NW]. Lane 0 is least significant.
  - A beat completes a word if idx==RATIO-1, or if flush is enabled and IN_EOM=1.
- Non-completing accept: idx increments by 1.
- Completing accept:
  - out_data <= acc merged with the new lane; lanes above idx are forced to 0.
  - out_cnt <= idx+1; out_eom <= IN_EOM (flush enabled) or 0.
  - out_pend <= 1; idx <= 0; acc <= 0.
- OUT_ENQ with no completing accept in the same cycle: out_pend <= 0.
- OUT_ENQ and a completing accept in the same cycle: out_pend stays 1 and the new word replaces the old one. There is no bubble.
- Outputs: OUT_DATA, OUT_COUNT and OUT_EOM are driven straight from out_data, out_cnt and out_eom.

## Timing
- Reset values:
  - Registers: idx=0, acc=0, out_pend=0, out_data=0, out_cnt=0, out_eom=0.
  - Outputs: IN_DEQ=0, OUT_ENQ=0, OUT_DATA=0, OUT_COUNT=0, OUT_EOM=0.
- Latency: a completing beat accepted at edge t gives OUT_ENQ=1 in cycle t+1, provided OUT_FULL_N=1.
- Throughput: one beat per cycle, one word per RATIO cycles, with OUT_FULL_N held high.
- Backpressure: the completing-beat path is the only one that needs the output slot. Stalling all accepts while blocked is the required, simpler behaviour.
- Reset mid-word: the partial accumulator and any pending word are discarded. No IN_DEQ or OUT_ENQ is issued in a cycle where RST=1.
- IN_EOM on lane RATIO-1 produces a normal full word with OUT_EOM=1 and OUT_COUNT=RATIO.
- IN_EOM on lane 0 produces OUT_COUNT=1, with lanes 1..RATIO-1 zero.

## Configuration
- Macro WORD_PACKER_EOM_FLUSH_EN.
  - Defined: IN_EOM forces completion of the current word. OUT_EOM and OUT_COUNT reflect the partial word as described above.
  - Undefined: IN_EOM is ignored. Completion happens only at idx==RATIO-1. OUT_EOM is tied to 0. OUT_COUNT reads RATIO whenever out_pend=1 and 0 after reset.

## Test plan
All scenarios use NW=8 and RATIO=4.
- Basic pack: beats 0x11, 0x22, 0x33, 0x44 back-to-back with OUT_FULL_N=1. Required: a single OUT_ENQ pulse one cycle after the 4th IN_DEQ, with OUT_DATA=0x44332211, OUT_COUNT=4, OUT_EOM=0.
- Backpressure: after word 0x44332211 is pending, hold OUT_FULL_N=0 for 5 cycles while beats 0x55..0x88 are available. Required: IN_DEQ=0 and OUT_ENQ=0 throughout. After release, 0x44332211 is enqueued, then 0x88776655, with no beat lost or duplicated.
- EOM flush (macro defined): beats 0xAA, then 0xBB with IN_EOM=1, followed by 0x01..0x04. Required: first word OUT_DATA=0x0000BBAA, OUT_COUNT=2, OUT_EOM=1; second word 0x04030201, OUT_COUNT=4, OUT_EOM=0.
- Same stimulus with the macro undefined. Required: first word 0x0201BBAA with OUT_COUNT=4 and OUT_EOM=0; the remaining beats 0x03, 0x04 stay in the accumulator.
- Reset mid-word: beats 0x10, 0x20, then RST=1 for one cycle, then beats 0x01..0x04. Required: only one word is produced, 0x04030201, and no IN_DEQ occurs during the RST cycle.
- Streaming: 16 consecutive beats 0x00..0x0F with OUT_FULL_N=1. Required: IN_DEQ high all 16 cycles and OUT_ENQ pulsing every 4th cycle. Words are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.

Source files
------------

// File: rtl/fifo_word_packer.sv
// ---------------------------------------------------------------------------
// fifo_word_packer
//
// Width-up packer placed between two depth-2 FIFO stages. Narrow beats are
// dequeued from the upstream FIFO and collected, lane 0 first, into one wide
// word of RATIO lanes. Each finished word is held in a one-entry output
// register and enqueued into the downstream FIFO. With OUT_FULL_N held high
// the block accepts one beat every cycle.
//
// Optional feature (compile-time macro WORD_PACKER_EOM_FLUSH_EN):
//   defined   - IN_EOM closes the current word early. OUT_COUNT gives the
//               number of valid lanes and OUT_EOM marks the closing word.
//   undefined - IN_EOM is ignored. Words close only when every lane is
//               filled, and OUT_EOM is always 0.
//
// Parameters:
//   NW    - narrow beat width in bits
//   RATIO - beats per wide word (power of two, 2..16)
//   CW    - width of OUT_COUNT
//
// Ports:
//   CLK         in   clock
//   RST         in   synchronous reset, active high
//   IN_DATA     in   upstream FIFO head data
//   IN_EOM      in   end-of-message flag that travels with IN_DATA
//   IN_EMPTY_N  in   upstream FIFO holds data
//   IN_DEQ      out  dequeue strobe to the upstream FIFO
//   OUT_DATA    out  packed word, lane 0 least significant
//   OUT_COUNT   out  number of valid lanes in OUT_DATA
//   OUT_EOM     out  word closes a message
//   OUT_ENQ     out  enqueue strobe to the downstream FIFO
//   OUT_FULL_N  in   downstream FIFO has space
// ---------------------------------------------------------------------------
module fifo_word_packer #(
    parameter int NW    = 8,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NW-1:0]       IN_DATA,
    input  logic                IN_EOM,
    input  logic                IN_EMPTY_N,
    output logic                IN_DEQ,
    output logic [NW*RATIO-1:0] OUT_DATA,
    output logic [CW-1:0]       OUT_COUNT,
    output logic                OUT_EOM,
    output logic                OUT_ENQ,
    input  logic                OUT_FULL_N
);

    localparam int IW = $clog2(RATIO);

    typedef logic [IW-1:0] idx_t;

    idx_t                idx;
    logic [NW*RATIO-1:0] acc;
    logic                out_pend;
    logic [NW*RATIO-1:0] out_data;
    logic [CW-1:0]       out_cnt;
    logic                out_eom;

    logic                eom_hit;
    logic                last_lane;
    logic                complete;
    logic [NW*RATIO-1:0] merged;

`ifdef WORD_PACKER_EOM_FLUSH_EN
    assign eom_hit = IN_EOM;
`else
    logic unused_in_eom;
    assign unused_in_eom = IN_EOM;
    assign eom_hit       = 1'b0;
`endif

    // A blocked pending word stalls every accept, not just completing ones.
    // Only the completing beat needs the output slot, but stalling all
    // accepts keeps the handshake trivial and loses no throughput once the
    // downstream FIFO drains.
    assign IN_DEQ  = !RST && IN_EMPTY_N && !(out_pend && !OUT_FULL_N);
    assign OUT_ENQ = !RST && out_pend && OUT_FULL_N;

    assign last_lane = (idx == idx_t'(RATIO - 1));
    assign complete  = IN_DEQ && (last_lane || eom_hit);

    // Accumulator with the incoming beat dropped into lane idx. Lanes above
    // idx are forced to zero so a flushed partial word never carries stale
    // data in its unused lanes.
    always_comb begin
        merged = acc;
        for (int l = 0; l < RATIO; l++) begin
            if (idx_t'(l) == idx) begin
                merged[l*NW +: NW] = IN_DATA;
            end else if (idx_t'(l) > idx) begin
                merged[l*NW +: NW] = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx      <= '0;
            acc      <= '0;
            out_pend <= 1'b0;
            out_data <= '0;
            out_cnt  <= '0;
            out_eom  <= 1'b0;
        end else begin
            if (IN_DEQ) begin
                if (complete) begin
                    out_data <= merged;
                    out_cnt  <= CW'(idx) + CW'(1);
                    out_eom  <= eom_hit;
                    out_pend <= 1'b1;
                    idx      <= '0;
                    acc      <= '0;
                end else begin
                    acc <= merged;
                    idx <= idx + idx_t'(1);
                end
            end
            // A word enqueued in the same cycle that another completes is
            // simply replaced, so back-to-back words leave no bubble.
            if (OUT_ENQ && !complete) begin
                out_pend <= 1'b0;
            end
        end
    end

    assign OUT_DATA  = out_data;
    assign OUT_COUNT = out_cnt;
    assign OUT_EOM   = out_eom;

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

    localparam int NW    = 8;
    localparam int RATIO = 4;
    localparam int CW    = $clog2(RATIO) + 1;

`ifdef WORD_PACKER_EOM_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic [NW-1:0]       IN_DATA;
    logic                IN_EOM;
    logic                IN_EMPTY_N;
    logic                IN_DEQ;
    logic [NW*RATIO-1:0] OUT_DATA;
    logic [CW-1:0]       OUT_COUNT;
    logic                OUT_EOM;
    logic                OUT_ENQ;
    logic                OUT_FULL_N;

    fifo_word_packer #(.NW(NW), .RATIO(RATIO), .CW(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_DATA    (IN_DATA),
        .IN_EOM     (IN_EOM),
        .IN_EMPTY_N (IN_EMPTY_N),
        .IN_DEQ     (IN_DEQ),
        .OUT_DATA   (OUT_DATA),
        .OUT_COUNT  (OUT_COUNT),
        .OUT_EOM    (OUT_EOM),
        .OUT_ENQ    (OUT_ENQ),
        .OUT_FULL_N (OUT_FULL_N)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NW*RATIO-1:0] data;
        int                  cnt;
        bit                  eom;
    } word_t;

    typedef struct {
        bit                  rst;
        logic [NW-1:0]       d;
        bit                  eom;
        bit                  en;
        bit                  fn;
        bit                  deq;
        bit                  enq;
        logic [NW*RATIO-1:0] word;
        int                  cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int deq_cnt  = 0;

    // Reference model: beats of the word being built, and finished words
    // waiting for the downstream FIFO (never more than one).
    logic [NW-1:0] part[$];
    word_t         pend_q[$];
    word_t         seen[$];
    int            enq_cyc[$];
    vec_t          tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(bit rst, logic [NW-1:0] d, bit eom, bit en, bit fn,
                                bit deq, bit enq, logic [NW*RATIO-1:0] word, int cnt);
        vec_t v;
        v.rst = rst; v.d = d; v.eom = eom; v.en = en; v.fn = fn;
        v.deq = deq; v.enq = enq; v.word = word; v.cnt = cnt;
        return v;
    endfunction

    // Called at the negedge: checks handshakes against the model, then
    // advances the model by the edge that follows.
    task automatic model_tick();
        bit    exp_deq, exp_enq;
        word_t w;
        exp_enq = !RST && pend_q.size() > 0 && OUT_FULL_N;
        exp_deq = !RST && IN_EMPTY_N && !(pend_q.size() > 0 && !OUT_FULL_N);
        chk("in_deq", IN_DEQ, exp_deq);
        chk("out_enq", OUT_ENQ, exp_enq);
        if (IN_DEQ) deq_cnt++;
        if (OUT_ENQ) begin
            w.data = OUT_DATA; w.cnt = int'(OUT_COUNT); w.eom = OUT_EOM;
            seen.push_back(w);
            enq_cyc.push_back(cyc);
        end
        if (exp_enq) begin
            chk("model_data", OUT_DATA, pend_q[0].data);
            chk("model_count", OUT_COUNT, pend_q[0].cnt);
            chk("model_eom", OUT_EOM, pend_q[0].eom);
        end
        if (RST) begin
            part.delete();
            pend_q.delete();
        end else begin
            if (exp_enq) void'(pend_q.pop_front());
            if (exp_deq) begin
                part.push_back(IN_DATA);
                if (part.size() == RATIO || (FLUSH && IN_EOM)) begin
                    w.data = '0;
                    foreach (part[i]) w.data[i*NW +: NW] = part[i];
                    w.cnt = part.size();
                    w.eom = FLUSH && IN_EOM;
                    pend_q.push_back(w);
                    part.delete();
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge CLK);
        model_tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(bit rst, logic [NW-1:0] d, bit eom, bit en, bit fn);
        RST = rst; IN_DATA = d; IN_EOM = eom; IN_EMPTY_N = en; OUT_FULL_N = fn;
    endtask

    task automatic beat(logic [NW-1:0] d, bit eom);
        drive(0, d, eom, 1, 1);
        step();
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0, 1);
        step();
    endtask

    initial begin
        drive(1, 8'h00, 0, 1, 1);
        @(posedge CLK); #1;
        step();                      // reset cycle with data present: no IN_DEQ
        drive(0, 8'h00, 0, 0, 1);
        @(negedge CLK);
        chk("reset_out_data", OUT_DATA, 0);
        chk("reset_out_count", OUT_COUNT, 0);
        chk("reset_out_eom", OUT_EOM, 0);
        chk("reset_out_enq", OUT_ENQ, 0);
        @(posedge CLK); #1;

        // Basic pack
        tbl.push_back(mk(0, 8'h11, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h22, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h33, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h44, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 32'h44332211, 4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
        // Backpressure
        tbl.push_back(mk(0, 8'h11, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h22, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h33, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h44, 0, 1, 1, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h55, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h55, 0, 1, 1, 1, 1, 32'h44332211, 4));
        tbl.push_back(mk(0, 8'h66, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h77, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h88, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 32'h88776655, 4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
        // Reset mid-word
        tbl.push_back(mk(0, 8'h10, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h20, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h30, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h01, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h02, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h03, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h04, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 32'h04030201, 4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].d, tbl[i].eom, tbl[i].en, tbl[i].fn);
            @(negedge CLK);
            chk("tbl_in_deq", IN_DEQ, tbl[i].deq);
            chk("tbl_out_enq", OUT_ENQ, tbl[i].enq);
            if (tbl[i].enq) begin
                chk("tbl_out_data", OUT_DATA, tbl[i].word);
                chk("tbl_out_count", OUT_COUNT, tbl[i].cnt);
                chk("tbl_out_eom", OUT_EOM, 0);
            end
            model_tick();
            @(posedge CLK); #1;
        end

        // EOM handling
        seen.delete();
        beat(8'hAA, 0);
        beat(8'hBB, 1);
        for (int i = 1; i <= 6; i++) beat(8'(i), 0);
        idle();
        idle();
        chk("eom_word_total", seen.size(), 2);
        if (seen.size() == 2) begin
            if (FLUSH) begin
                chk("eom_w0_data", seen[0].data, 32'h0000BBAA);
                chk("eom_w0_count", seen[0].cnt, 2);
                chk("eom_w0_eom", seen[0].eom, 1);
                chk("eom_w1_data", seen[1].data, 32'h04030201);
                chk("eom_w1_count", seen[1].cnt, 4);
            end else begin
                chk("eom_w0_data", seen[0].data, 32'h0201BBAA);
                chk("eom_w0_count", seen[0].cnt, 4);
                chk("eom_w0_eom", seen[0].eom, 0);
                chk("eom_w1_data", seen[1].data, 32'h06050403);
                chk("eom_w1_count", seen[1].cnt, 4);
            end
            chk("eom_w1_eom", seen[1].eom, 0);
        end
        // EOM on the last lane closes a full word and is flagged when enabled
        seen.delete();
        drive(1, 8'h00, 0, 0, 1);
        step();
        beat(8'hC0, 0);
        beat(8'hC1, 0);
        beat(8'hC2, 0);
        beat(8'hC3, 1);
        idle();
        chk("eom_last_total", seen.size(), 1);
        if (seen.size() == 1) begin
            chk("eom_last_data", seen[0].data, 32'hC3C2C1C0);
            chk("eom_last_count", seen[0].cnt, 4);
            chk("eom_last_eom", seen[0].eom, FLUSH);
        end

        // Streaming
        seen.delete();
        enq_cyc.delete();
        deq_cnt = 0;
        begin
            int c0;
            c0 = cyc;
            for (int i = 0; i < 16; i++) beat(8'(i), 0);
            idle();
            chk("stream_deq_cycles", deq_cnt, 16);
            chk("stream_word_total", seen.size(), 4);
            for (int i = 0; i < 4 && i < seen.size(); i++) begin
                chk("stream_word", seen[i].data,
                    {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
                chk("stream_enq_cycle", enq_cyc[i] - c0, 4*i + 4);
            end
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 49) == 0, 8'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            step();
        end
        for (int i = 0; i < 4; i++) idle();
        chk("drain_empty", pend_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
